// File: rtl/fifo_unpacker_128_pkg.sv
// Shared constants for the 128-bit FIFO unpacker: FSM state codes, default
// widths and the lane-index width helper.
package fifo_unpacker_128_pkg;

    localparam int DEF_IN_WIDTH  = 128;
    localparam int DEF_OUT_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    function automatic int lane_w(input int ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/fifo_unpacker_128.sv
// Drains IN_WIDTH words from a simple FIFO and emits them as OUT_WIDTH lanes on
// a valid/ready stream. Define UNPACK_MSB_FIRST_EN to emit the top lane first.
module fifo_unpacker_128
    import fifo_unpacker_128_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 fifo_re,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    input  logic                 fifo_empty,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [31:0]          lane_count
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int LW    = lane_w(RATIO);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [1:0]          state;
    logic [LW-1:0]       lane;
    logic [LW-1:0]       sel;
    logic [IN_WIDTH-1:0] word;
    logic                at_last;
    logic                hs;

    assign at_last = (lane == LAST_LANE);
    assign hs      = reset && (state == ST_EMIT) && out_ready;

`ifdef UNPACK_MSB_FIRST_EN
    assign sel = LAST_LANE - lane;
`else
    assign sel = lane;
`endif

    assign out_valid = reset && (state == ST_EMIT);
    assign out_last  = out_valid && at_last;
    assign out_data  = reset ? word[sel*OUT_WIDTH +: OUT_WIDTH] : '0;

    // The final-lane handshake pops the next word in the same cycle, so a
    // busy stream costs only one bubble per word.
    always_comb begin
        fifo_re = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: fifo_re = !fifo_empty;
                ST_EMIT: fifo_re = hs && at_last && !fifo_empty;
                default: fifo_re = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            lane       <= '0;
            word       <= '0;
            lane_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_re) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    word  <= fifo_dout;
                    lane  <= '0;
                    state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (hs) begin
                        if (!at_last) lane <= lane + 1'b1;
                        else          state <= fifo_re ? ST_WAIT : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (hs) lane_count <= lane_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fifo_unpacker_128.sv
// Randomized self-checking bench for fifo_unpacker_128 with a queue-based FIFO
// model and a lane scoreboard built from the words pushed.
module tb_fifo_unpacker_128;

    localparam int IW = 128;
    localparam int OW = 32;
    localparam int R  = IW / OW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_re;
    logic [IW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [31:0]   lane_count;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          l;
    } lane_t;

    int            n_vec = 0;
    int            n_err = 0;
    logic [IW-1:0] fq[$];
    lane_t         exp_q[$];
    logic [31:0]   mcnt = '0;
    logic [31:0]   pre_val = '0;
    int            pre_seq = 0;
    int            seen_seq = 0;

    always #5 clk = ~clk;

    fifo_unpacker_128 #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_re    (fifo_re),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .lane_count (lane_count)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Lane k of a word, as the consumer should see it.
    function automatic logic [OW-1:0] lane_of(input logic [IW-1:0] w, input int k);
        int p;
`ifdef UNPACK_MSB_FIRST_EN
        p = R - 1 - k;
`else
        p = k;
`endif
        return OW'(w >> (p * OW));
    endfunction

    task automatic push(input logic [IW-1:0] w);
        fq.push_back(w);
        for (int k = 0; k < R; k++) exp_q.push_back('{d: lane_of(w, k), l: (k == R - 1)});
    endtask

    // FIFO model: data valid the cycle after a pop; empty flag refreshed mid-cycle.
    always begin
        @(posedge clk);
        if (!reset) begin
            fq.delete();
            fifo_empty = 1'b1;
        end else if (fifo_re) begin
            if (fq.size() != 0) fifo_dout <= fq.pop_front();
            else                fifo_dout <= 'x;
        end
        @(negedge clk);
        #2;
        fifo_empty = (fq.size() == 0);
    end

    // Scoreboard: samples just before each rising edge.
    logic [OW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;
    logic          hold   = 1'b0;
    always begin
        lane_t e;
        @(negedge clk);
        #4;
        if (pre_seq != seen_seq) begin
            seen_seq = pre_seq;
            mcnt     = pre_val;
        end
        if (!reset) begin
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_re", fifo_re, 1'b0);
            exp_q.delete();
            mcnt = '0;
            hold = 1'b0;
        end else begin
            chk("re_while_empty", fifo_re && fifo_empty, 1'b0);
            chk("lane_count", lane_count, mcnt);
            if (hold) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, hold_d);
                chk("hold_last", out_last, hold_l);
            end
            if (out_valid && out_ready) begin
                chk("lane_avail", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("lane_data", out_data, e.d);
                    chk("lane_last", out_last, e.l);
                end
                mcnt = mcnt + 32'd1;
            end
            hold   = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
        end
    end

    task automatic wait_lane(input logic [OW-1:0] v, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 16 && !hit; i++) begin
            #3;
            hit = out_valid && (out_data == v);
            if (!hit) @(negedge clk);
        end
        chk(tag, hit, 1'b1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 80 && (exp_q.size() != 0 || out_valid || fifo_re); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] w0, wb, wr, wn;
        logic [31:0]   sbase;
        int            hs_n, first_c, last_c, bubbles;

        w0 = 128'h44444444_33333333_22222222_11111111;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_lane_count", lane_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single word, timing from empty falling, lane order, idle afterwards
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk);
            push(w0);
            out_ready = 1'b1;
            #3;
            chk("pop_on_nonempty", fifo_re, 1'b1);
            @(negedge clk); #3;
            chk("wait_no_valid", out_valid, 1'b0);
            chk("wait_no_re", fifo_re, 1'b0);
            @(negedge clk); #3;
            for (int k = 0; k < R; k++) begin
                chk("single_valid", out_valid, 1'b1);
`ifdef UNPACK_MSB_FIRST_EN
                chk("single_data", out_data, 32'h11111111 * (R - k));
`else
                chk("single_data", out_data, 32'h11111111 * (k + 1));
`endif
                chk("single_last", out_last, k == R - 1);
                @(negedge clk); #3;
            end
            for (int i = 0; i < 3; i++) begin
                chk("idle_valid", out_valid, 1'b0);
                chk("idle_re", fifo_re, 1'b0);
                @(negedge clk); #3;
            end
        end

        // Streaming: 3 words, one bubble between words
        @(negedge clk);
        sbase = mcnt;
        for (int i = 0; i < 3; i++) push({$urandom(), $urandom(), $urandom(), $urandom()});
        out_ready = 1'b1;
        hs_n = 0; first_c = -1; last_c = -1; bubbles = 0;
        for (int c = 0; c < 25; c++) begin
            #3;
            if (out_valid && out_ready) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                hs_n++;
            end else if (!out_valid && hs_n > 0 && hs_n < 3 * R) begin
                bubbles++;
            end
            @(negedge clk);
        end
        chk("stream_lanes", hs_n, 3 * R);
        chk("stream_span", last_c - first_c, 3 * R + 1);
        chk("stream_bubbles", bubbles, 2);
        #3;
        chk("stream_count", lane_count, sbase + 32'd12);
        drain();

        // Backpressure on lane 2
        @(negedge clk);
        wb = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
        push(wb);
        out_ready = 1'b1;
        wait_lane(lane_of(wb, 2), "bp_find_lane2");
        out_ready = 1'b0;
        sbase = mcnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #3;
            chk("bp_data", out_data, lane_of(wb, 2));
            chk("bp_last", out_last, 1'b0);
            chk("bp_no_re", fifo_re, 1'b0);
            chk("bp_count", lane_count, sbase);
        end
        drain();
        chk("bp_count_after", lane_count, sbase + 32'd2);

        // Reset mid-word, then restart from lane 0
        @(negedge clk);
        wr = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
        wn = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
        push(wr);
        out_ready = 1'b1;
        wait_lane(lane_of(wr, 1), "rst_find_lane1");
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #3;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_data", out_data, '0);
        chk("rst_mid_last", out_last, 1'b0);
        @(negedge clk); #3;
        chk("rst_mid_count", lane_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        push(wn);
        wait_lane(lane_of(wn, 0), "restart_lane0");
        drain();

        // Counter wrap
        @(negedge clk);
        force dut.lane_count = 32'hFFFF_FFFE;
        pre_val = 32'hFFFF_FFFE;
        pre_seq++;
        @(negedge clk);
        release dut.lane_count;
        push({$urandom(), $urandom(), $urandom(), $urandom()});
        drain();
        chk("wrap_count", lane_count, 32'd2);

        // Random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 4) == 0 && fq.size() < 4)
                push({$urandom(), $urandom(), $urandom(), $urandom()});
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
